// File: rtl/matmul_loop_sequencer.sv
// Loop sequencer for C = A*B: walks i/j/k, issues one operand tuple per k step
// to the FP MAC over valid/ready, and bounds retired-pending dot products by credits.
module matmul_loop_sequencer #(
  parameter int DIM_W   = 32,
  parameter int ADDR_W  = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  num_i,
  input  logic [DIM_W-1:0]  num_j,
  input  logic [DIM_W-1:0]  num_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_addr_a,
  output logic [ADDR_W-1:0] op_addr_b,
  output logic [ADDR_W-1:0] op_addr_c,
  output logic              op_first,
  output logic              op_last,
  input  logic              res_done,
  output logic [DIM_W-1:0]  cur_i,
  output logic [DIM_W-1:0]  cur_j,
  output logic [DIM_W-1:0]  cur_k,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  ni_q, ni_d, nj_q, nj_d, nk_q, nk_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  // addr_a/b/c track the presented tuple; row_a is A's row start, col_b is B's column start
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
  logic [ADDR_W-1:0] row_a_q, row_a_d, col_b_q, col_b_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              err_q, err_d;

  logic in_run, last_i, last_j, last_k, xfer, inc;

  assign in_run    = (state_q == S_RUN);
  assign last_i    = (i_q == ni_q - DIM_W'(1));
  assign last_j    = (j_q == nj_q - DIM_W'(1));
  assign last_k    = (k_q == nk_q - DIM_W'(1));
  // Only the closing tuple of a dot product needs a credit, so only it stalls
  assign op_valid  = in_run && !((credits_q == CW'(MAX_OUT)) && last_k);
  assign op_first  = in_run && (k_q == '0);
  assign op_last   = in_run && last_k;
  assign xfer      = op_valid && op_ready;
  assign inc       = xfer && op_last;
  assign op_addr_a = addr_a_q;
  assign op_addr_b = addr_b_q;
  assign op_addr_c = addr_c_q;
  assign cur_i     = i_q;
  assign cur_j     = j_q;
  assign cur_k     = k_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

  // Next-state: credit accounting, loop advance with incremental addressing, FSM
  always_comb begin
    state_d   = state_q;
    ni_d      = ni_q;
    nj_d      = nj_q;
    nk_d      = nk_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    base_b_d  = base_b_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    addr_c_d  = addr_c_q;
    row_a_d   = row_a_q;
    col_b_d   = col_b_q;
    credits_d = credits_q;
    err_d     = err_q;

    if (inc && !res_done) begin
      credits_d = credits_q + CW'(1);
    end else if (!inc && res_done) begin
      if (credits_q == '0) err_d = 1'b1;
      else                 credits_d = credits_q - CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ni_d     = num_i;
          nj_d     = num_j;
          nk_d     = num_k;
          base_b_d = base_b;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          addr_a_d = base_a;
          row_a_d  = base_a;
          addr_b_d = base_b;
          col_b_d  = base_b;
          addr_c_d = base_c;
          err_d    = 1'b0;
          state_d  = ((num_i == '0) || (num_j == '0) || (num_k == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (!last_k) begin
            k_d      = k_q + DIM_W'(1);
            addr_a_d = addr_a_q + ADDR_W'(1);
            addr_b_d = addr_b_q + ADDR_W'(nj_q);
          end else begin
            k_d      = '0;
            addr_c_d = addr_c_q + ADDR_W'(1);
            if (!last_j) begin
              j_d      = j_q + DIM_W'(1);
              addr_a_d = row_a_q;
              col_b_d  = col_b_q + ADDR_W'(1);
              addr_b_d = col_b_q + ADDR_W'(1);
            end else begin
              // End of row i: next A row starts right after the last element of this one
              j_d      = '0;
              addr_a_d = addr_a_q + ADDR_W'(1);
              row_a_d  = addr_a_q + ADDR_W'(1);
              col_b_d  = base_b_q;
              addr_b_d = base_b_q;
              if (last_i) state_d = S_DRAIN;
              else        i_d     = i_q + DIM_W'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (credits_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ni_q      <= '0;
      nj_q      <= '0;
      nk_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      base_b_q  <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      row_a_q   <= '0;
      col_b_q   <= '0;
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ni_q      <= ni_d;
      nj_q      <= nj_d;
      nk_q      <= nk_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      base_b_q  <= base_b_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      addr_c_q  <= addr_c_d;
      row_a_q   <= row_a_d;
      col_b_q   <= col_b_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_matmul_loop_sequencer.sv
// Bench for matmul_loop_sequencer: a nested-loop reference of the expected tuple
// stream, a credit/retire model and a delayed-retire MAC responder.
module tb_matmul_loop_sequencer;
  localparam int DIM_W = 32, ADDR_W = 16, MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset, start, op_ready, res_done;
  logic [DIM_W-1:0]  num_i, num_j, num_k;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic op_valid, op_first, op_last, busy, done, err;
  logic [ADDR_W-1:0] op_addr_a, op_addr_b, op_addr_c;
  logic [DIM_W-1:0]  cur_i, cur_j, cur_k;

  matmul_loop_sequencer #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_i(num_i), .num_j(num_j), .num_k(num_k),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_addr_a(op_addr_a), .op_addr_b(op_addr_b), .op_addr_c(op_addr_c),
    .op_first(op_first), .op_last(op_last), .res_done(res_done),
    .cur_i(cur_i), .cur_j(cur_j), .cur_k(cur_k),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // tuple layout: {a[145:130], b[129:114], c[113:98], first[97], last[96], i, j, k}
  logic [145:0] exp_q[$];
  int ret_q[$];
  int checks = 0, errors = 0, cyc = 0, outst = 0, n_xfer = 0, n_done = 0;
  int ret_delay = 3, ready_mode = 0, x0, d0;
  bit active = 0, exp_done = 0, exp_err = 0, auto_ret = 1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [145:0] tup_now();
    return {op_addr_a, op_addr_b, op_addr_c, op_first, op_last, cur_i, cur_j, cur_k};
  endfunction

  // Expected tuple stream straight from the matrix-index formulas
  task automatic build(input int ni, input int nj, input int nk,
                       input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
    logic [15:0] a, b, c;
    exp_q.delete();
    for (int i = 0; i < ni; i++)
      for (int j = 0; j < nj; j++)
        for (int k = 0; k < nk; k++) begin
          a = 16'(int'(ba) + i * nk + k);
          b = 16'(int'(bb) + k * nj + j);
          c = 16'(int'(bc) + i * nj + j);
          exp_q.push_back({a, b, c, (k == 0), (k == nk - 1), 32'(i), 32'(j), 32'(k)});
        end
  endtask

  // One clock: observe pre-edge handshake, advance model, check, drive next inputs
  task automatic step();
    bit xfer, lastx, rd, acc;
    int ni, nj, nk, t;
    logic [15:0] ba, bb, bc;
    rd    = (res_done === 1'b1);
    xfer  = (op_valid === 1'b1) && (op_ready === 1'b1);
    lastx = xfer && (op_last === 1'b1);
    acc   = (start === 1'b1) && !active && !exp_done;
    ni = int'(num_i); nj = int'(num_j); nk = int'(num_k);
    ba = base_a; bb = base_b; bc = base_c;
    @(posedge clk); #1; cyc++;
    if (xfer) begin
      n_xfer++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (lastx) begin
        outst++;
        if (auto_ret) begin
          t = cyc + ret_delay;
          if (ret_q.size() > 0 && t <= ret_q[$]) t = ret_q[$] + 1;
          ret_q.push_back(t);
        end
      end
    end
    if (rd) begin
      if (outst == 0) exp_err = 1;
      else outst--;
    end
    exp_done = 0;
    if (acc) begin
      exp_err = 0;
      if (ni == 0 || nj == 0 || nk == 0) exp_done = 1;
      else begin build(ni, nj, nk, ba, bb, bc); active = 1; end
    end else if (active && exp_q.size() == 0 && outst == 0) begin
      active = 0;
      exp_done = 1;
    end
    if (done === 1'b1) n_done++;
    chk("done", done, exp_done);
    chk("busy", busy, active);
    chk("err", err, exp_err);
    if (active && exp_q.size() > 0)
      chk("op_valid", op_valid, !(outst == MAX_OUT && exp_q[0][96]));
    else
      chk("op_valid_off", op_valid, 1'b0);
    if (op_valid === 1'b1 && exp_q.size() > 0) chk("tuple", tup_now(), exp_q[0]);
    res_done = 1'b0;
    if (auto_ret && ret_q.size() > 0 && ret_q[0] <= cyc) begin
      res_done = 1'b1;
      void'(ret_q.pop_front());
    end
    if (ready_mode == 0) op_ready = 1'b1;
    else if (ready_mode == 1) op_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_mm(input int ni, input int nj, input int nk,
                          input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
    num_i = 32'(ni); num_j = 32'(nj); num_k = 32'(nk);
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      if (!active) break;
      step();
    end
    chk("run_timeout", active, 1'b0);
    step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_ready = 1'b1; res_done = 1'b0;
    num_i = '0; num_j = '0; num_k = '0; base_a = '0; base_b = '0; base_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {op_valid, op_addr_a, op_addr_b, op_addr_c, op_first, op_last,
                        cur_i, cur_j, cur_k, busy, done, err}, '0);
    reset = 1'b1;
    step();

    // 2x2x2 directed: 8 tuples, one done pulse
    ready_mode = 0; ret_delay = 3; x0 = n_xfer; d0 = n_done;
    start_mm(2, 2, 2, 16'h000, 16'h100, 16'h200);
    wait_idle();
    chk("xfers_2x2x2", n_xfer - x0, 8);
    chk("done_pulses_2x2x2", n_done - d0, 1);

    // zero dimension: straight to done, no tuples
    x0 = n_xfer;
    start_mm(2, 0, 3, 16'h010, 16'h020, 16'h030);
    wait_idle();
    chk("xfers_zero_dim", n_xfer - x0, 0);

    // 1x1x3 with op_ready held low on the k=1 tuple
    ready_mode = 2; op_ready = 1'b1; x0 = n_xfer;
    start_mm(1, 1, 3, 16'h040, 16'h050, 16'h060);
    for (int t = 0; t < 10; t++) begin
      if (op_valid === 1'b1 && cur_k === 32'd1) break;
      step();
    end
    chk("hold_cur_k", cur_k, 32'd1);
    op_ready = 1'b0;
    repeat (5) step();
    op_ready = 1'b1;
    wait_idle();
    chk("xfers_hold", n_xfer - x0, 3);

    // credit stall 1x8x1: retires withheld, then a single retire
    ready_mode = 0; auto_ret = 0; x0 = n_xfer;
    start_mm(1, 8, 1, 16'h0, 16'h0, 16'h300);
    repeat (8) step();
    chk("xfers_credit_stall", n_xfer - x0, 4);
    res_done = 1'b1;
    step();
    repeat (5) step();
    chk("xfers_after_one_retire", n_xfer - x0, 5);
    auto_ret = 1;
    for (int n = 0; n < outst; n++) ret_q.push_back(cyc + 1 + n);
    wait_idle();
    chk("xfers_credit_total", n_xfer - x0, 8);

    // asynchronous reset in the middle of a 4x4x4 run
    ready_mode = 1; ret_delay = 2;
    start_mm(4, 4, 4, 16'($urandom), 16'($urandom), 16'($urandom));
    repeat (12) step();
    #3 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {op_valid, op_addr_a, op_addr_b, op_addr_c, op_first, op_last,
                                cur_i, cur_j, cur_k, busy, done, err}, '0);
    exp_q.delete(); ret_q.delete();
    outst = 0; active = 0; exp_done = 0; exp_err = 0;
    res_done = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ready_mode = 0;
    start_mm(2, 2, 2, 16'h1234, 16'h2345, 16'h3456);
    chk("restart_first_tuple", {cur_i, cur_j, cur_k, op_valid}, {96'd0, 1'b1});
    wait_idle();

    // res_done in IDLE sets sticky err; the next accepted start clears it
    auto_ret = 0;
    res_done = 1'b1;
    step();
    repeat (3) step();
    chk("err_sticky", err, 1'b1);
    auto_ret = 1;
    start_mm(1, 1, 1, 16'h5, 16'h6, 16'h7);
    wait_idle();

    // randomized runs, including address wrap and random back-pressure
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      ret_delay = $urandom_range(1, 6);
      x0 = n_xfer;
      start_mm($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(1, 4),
               16'($urandom_range(16'hFFF0, 16'hFFFF)), 16'($urandom), 16'($urandom));
      wait_idle();
      chk("rand_xfers", n_xfer - x0, int'(num_i) * int'(num_j) * int'(num_k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
